// File: rtl/auth_resp_arbiter_if.sv
// Bus bundle for auth_resp_arbiter: requester-side handshake and
// responder-side request/response/ack lines.
`ifndef MSG_LEN
`define MSG_LEN 64
`endif

interface auth_resp_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int MSG_LEN = `MSG_LEN
);
    // requester side
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*MSG_LEN-1:0] req_msg;
    logic [NUM_REQ-1:0]         req_grant;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [MSG_LEN-1:0]         rsp_msg;
    logic [NUM_REQ-1:0]         rsp_ack;
    // responder side
    logic                       resp_req_out;
    logic [MSG_LEN-1:0]         auth_msg_resp_out;
    logic                       resp_req_in;
    logic [MSG_LEN-1:0]         auth_msg_resp_in;
    logic                       Ack_out;
    // status
    logic                       busy;
    logic                       timeout_err;

    // arbiter view
    modport slave (
        input  req_valid, req_msg, rsp_ack, resp_req_in, auth_msg_resp_in,
        output req_grant, rsp_valid, rsp_msg, resp_req_out, auth_msg_resp_out,
               Ack_out, busy, timeout_err
    );

    // requester/responder environment view
    modport master (
        output req_valid, req_msg, rsp_ack, resp_req_in, auth_msg_resp_in,
        input  req_grant, rsp_valid, rsp_msg, resp_req_out, auth_msg_resp_out,
               Ack_out, busy, timeout_err
    );
endinterface

// File: rtl/auth_resp_arbiter.sv
// Round-robin arbiter sharing one authentication responder among NUM_REQ
// requesters, with a per-transaction timeout that synthesizes an ERROR
// response when the responder stays silent.
`ifndef MSG_LEN
`define MSG_LEN 64
`endif

module auth_resp_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int MSG_LEN        = `MSG_LEN,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic               clk,
    input  logic               reset,
    auth_resp_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    // ERROR header: version 1.1, ERROR, code 0x04, data 0; payload zero
    localparam logic [MSG_LEN-1:0] TMO_MSG = {32'h017F_0400, {(MSG_LEN-32){1'b0}}};

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RESP, DELIVER, RELEASE} state_t;

    state_t               state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     gnt_idx;
    logic [CNT_W-1:0]     cnt;
    logic [NUM_REQ-1:0]   req_grant_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic [MSG_LEN-1:0]   rsp_msg_q;
    logic [MSG_LEN-1:0]   auth_msg_q;
    logic                 resp_req_q;
    logic                 ack_q;
    logic                 busy_q;
    logic                 tmo_q;

    logic                 pick_vld;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W:0]       cand;
    logic [MSG_LEN-1:0]   pick_msg;
    logic [IDX_W-1:0]     rr_next;
    logic [NUM_REQ-1:0]   pick_oh;
    logic [NUM_REQ-1:0]   gnt_oh;

    // first pending request at or above rr_ptr, wrapping around
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ))
                cand = cand - (IDX_W+1)'(NUM_REQ);
            if (!pick_vld && bus.req_valid[cand[IDX_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[IDX_W-1:0];
            end
        end
    end

    // message slice of the selected requester
    always_comb begin
        pick_msg = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (pick_idx == IDX_W'(i))
                pick_msg = bus.req_msg[i*MSG_LEN +: MSG_LEN];
    end

    assign rr_next = (pick_idx == IDX_W'(NUM_REQ-1)) ? '0 : pick_idx + IDX_W'(1);
    assign pick_oh = NUM_REQ'(1) << pick_idx;
    assign gnt_oh  = NUM_REQ'(1) << gnt_idx;

    // transaction FSM; every output is a register updated here
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            gnt_idx     <= '0;
            cnt         <= '0;
            req_grant_q <= '0;
            rsp_valid_q <= '0;
            rsp_msg_q   <= '0;
            auth_msg_q  <= '0;
            resp_req_q  <= 1'b0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            req_grant_q <= '0;
            ack_q       <= 1'b0;
            tmo_q       <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        auth_msg_q  <= pick_msg;
                        req_grant_q <= pick_oh;
                        gnt_idx     <= pick_idx;
                        rr_ptr      <= rr_next;
                        busy_q      <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    resp_req_q <= 1'b1;
                    cnt        <= '0;
                    state      <= WAIT_RESP;
                end
                WAIT_RESP: begin
                    cnt <= cnt + CNT_W'(1);
                    // a real answer wins over a timeout on the same cycle
                    if (bus.resp_req_in) begin
                        rsp_msg_q   <= bus.auth_msg_resp_in;
                        resp_req_q  <= 1'b0;
                        ack_q       <= 1'b1;
                        rsp_valid_q <= gnt_oh;
                        state       <= DELIVER;
                    end else if (cnt == TMO_LAST) begin
                        rsp_msg_q   <= TMO_MSG;
                        resp_req_q  <= 1'b0;
                        tmo_q       <= 1'b1;
                        rsp_valid_q <= gnt_oh;
                        state       <= DELIVER;
                    end
                end
                DELIVER: begin
                    if (bus.rsp_ack[gnt_idx]) begin
                        rsp_valid_q <= '0;
                        state       <= RELEASE;
                    end
                end
                RELEASE: begin
                    // absorbs a late answer: hold off until the responder is idle
                    if (!bus.resp_req_in) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_grant         = req_grant_q;
    assign bus.rsp_valid         = rsp_valid_q;
    assign bus.rsp_msg           = rsp_msg_q;
    assign bus.resp_req_out      = resp_req_q;
    assign bus.auth_msg_resp_out = auth_msg_q;
    assign bus.Ack_out           = ack_q;
    assign bus.busy              = busy_q;
    assign bus.timeout_err       = tmo_q;

endmodule

// File: tb/tb_auth_resp_arbiter.sv
// Directed bench for auth_resp_arbiter: round robin, single request,
// same-cycle answer/timeout, timeout with late answer, async reset.
module tb_auth_resp_arbiter;
    localparam int NR = 4;
    localparam int MW = 64;
    localparam int TMO = 16;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    auth_resp_arbiter_if #(.NUM_REQ(NR), .MSG_LEN(MW)) bus ();

    auth_resp_arbiter #(
        .NUM_REQ(NR), .MSG_LEN(MW), .TIMEOUT_CYCLES(TMO), .CNT_W(5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [MW-1:0] msg_of(input int i);
        return {8'h01, 8'h10 + 8'(i), 16'h0000, 32'hC0DE_0000 + 32'(i)};
    endfunction

    function automatic logic [MW-1:0] oh(input int i);
        return MW'(1) << i;
    endfunction

    // full transaction with an immediate responder answer and immediate ack
    task automatic serve(input int idx, input logic [MW-1:0] r);
        tick;
        check("rr_grant", MW'(bus.req_grant), oh(idx));
        check("rr_msg_out", bus.auth_msg_resp_out, msg_of(idx));
        tick;
        check("rr_req_out", MW'(bus.resp_req_out), MW'(1));
        bus.resp_req_in = 1'b1;
        bus.auth_msg_resp_in = r;
        tick;
        check("rr_ack_out", MW'(bus.Ack_out), MW'(1));
        check("rr_rsp_valid", MW'(bus.rsp_valid), oh(idx));
        check("rr_rsp_msg", bus.rsp_msg, r);
        bus.resp_req_in = 1'b0;
        bus.rsp_ack = NR'(1) << idx;
        tick;
        check("rr_rsp_drop", MW'(bus.rsp_valid), MW'(0));
        bus.rsp_ack = '0;
        tick;
        check("rr_idle", MW'(bus.busy), MW'(0));
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        reset = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ack = '0;
        bus.resp_req_in = 1'b0;
        bus.auth_msg_resp_in = '0;
        for (int i = 0; i < NR; i++) bus.req_msg[i*MW +: MW] = msg_of(i);

        // reset state
        repeat (3) tick;
        check("rst_busy", MW'(bus.busy), MW'(0));
        check("rst_req_out", MW'(bus.resp_req_out), MW'(0));
        check("rst_msg_out", bus.auth_msg_resp_out, MW'(0));
        check("rst_rsp_msg", bus.rsp_msg, MW'(0));
        check("rst_grant", MW'(bus.req_grant), MW'(0));
        @(negedge clk);
        reset = 1'b1;
        tick;

        // round robin with all requesters held valid: 0,1,2,3,0
        bus.req_valid = 4'b1111;
        for (int t = 0; t < 5; t++) serve(t % NR, {32'h0101_0000, 32'hA000_0000 + 32'(t)});
        bus.req_valid = '0;
        tick;
        check("rr_quiet", MW'(bus.busy), MW'(0));

        // single request on requester 2, answer after a delay
        bus.req_valid = 4'b0100;
        tick;
        check("s_grant", MW'(bus.req_grant), MW'(4'b0100));
        check("s_busy", MW'(bus.busy), MW'(1));
        check("s_msg_out", bus.auth_msg_resp_out, msg_of(2));
        bus.req_valid = '0;  // dropping after grant must not cancel
        tick;
        check("s_grant_pulse", MW'(bus.req_grant), MW'(0));
        check("s_req_out1", MW'(bus.resp_req_out), MW'(1));
        for (int c = 0; c < 3; c++) begin
            tick;
            check("s_req_hold", MW'(bus.resp_req_out), MW'(1));
            check("s_no_ack", MW'(bus.Ack_out), MW'(0));
        end
        bus.resp_req_in = 1'b1;
        bus.auth_msg_resp_in = 64'h0101_0000_DEAD_BEEF;
        tick;
        check("s_req_drop", MW'(bus.resp_req_out), MW'(0));
        check("s_ack", MW'(bus.Ack_out), MW'(1));
        check("s_rsp_valid", MW'(bus.rsp_valid), MW'(4'b0100));
        check("s_rsp_msg", bus.rsp_msg, 64'h0101_0000_DEAD_BEEF);
        bus.resp_req_in = 1'b0;
        tick;
        check("s_ack_pulse", MW'(bus.Ack_out), MW'(0));
        check("s_rsp_hold", MW'(bus.rsp_valid), MW'(4'b0100));
        bus.rsp_ack = 4'b0001;  // wrong bit, ignored
        tick;
        check("s_wrong_ack", MW'(bus.rsp_valid), MW'(4'b0100));
        bus.rsp_ack = 4'b0100;
        tick;
        check("s_rsp_clr", MW'(bus.rsp_valid), MW'(0));
        check("s_release_busy", MW'(bus.busy), MW'(1));
        bus.rsp_ack = '0;
        tick;
        check("s_idle", MW'(bus.busy), MW'(0));

        // answer arrives on the very cycle the timeout would fire
        bus.req_valid = 4'b0010;
        tick;
        check("x_grant", MW'(bus.req_grant), MW'(4'b0010));
        bus.req_valid = '0;
        tick;
        repeat (TMO - 1) tick;
        check("x_req_before", MW'(bus.resp_req_out), MW'(1));
        check("x_tmo_before", MW'(bus.timeout_err), MW'(0));
        bus.resp_req_in = 1'b1;
        bus.auth_msg_resp_in = 64'h0101_0000_1234_5678;
        tick;
        check("x_ack", MW'(bus.Ack_out), MW'(1));
        check("x_tmo", MW'(bus.timeout_err), MW'(0));
        check("x_rsp_msg", bus.rsp_msg, 64'h0101_0000_1234_5678);
        bus.resp_req_in = 1'b0;
        bus.rsp_ack = 4'b0010;
        tick;
        bus.rsp_ack = '0;
        tick;
        check("x_idle", MW'(bus.busy), MW'(0));

        // timeout, then a late answer absorbed by RELEASE
        bus.req_valid = 4'b1000;
        tick;
        check("t_grant", MW'(bus.req_grant), MW'(4'b1000));
        bus.req_valid = '0;
        tick;
        repeat (TMO - 1) tick;
        check("t_req_last", MW'(bus.resp_req_out), MW'(1));
        tick;
        check("t_req_drop", MW'(bus.resp_req_out), MW'(0));
        check("t_tmo", MW'(bus.timeout_err), MW'(1));
        check("t_no_ack", MW'(bus.Ack_out), MW'(0));
        check("t_rsp_valid", MW'(bus.rsp_valid), MW'(4'b1000));
        check("t_rsp_msg", bus.rsp_msg, 64'h017F_0400_0000_0000);
        tick;
        check("t_tmo_pulse", MW'(bus.timeout_err), MW'(0));
        bus.resp_req_in = 1'b1;
        bus.auth_msg_resp_in = 64'h0101_0000_BAD0_BAD0;
        tick;
        check("l_no_ack", MW'(bus.Ack_out), MW'(0));
        check("l_rsp_msg", bus.rsp_msg, 64'h017F_0400_0000_0000);
        bus.rsp_ack = 4'b1000;
        tick;
        check("l_rsp_clr", MW'(bus.rsp_valid), MW'(0));
        bus.rsp_ack = '0;
        tick;
        tick;
        check("l_hold_release", MW'(bus.busy), MW'(1));
        check("l_no_ack2", MW'(bus.Ack_out), MW'(0));
        bus.resp_req_in = 1'b0;
        tick;
        check("l_idle", MW'(bus.busy), MW'(0));

        // async reset in the middle of WAIT_RESP
        bus.req_valid = 4'b0100;
        tick;
        check("r_grant", MW'(bus.req_grant), MW'(4'b0100));
        bus.req_valid = '0;
        repeat (3) tick;
        check("r_waiting", MW'(bus.resp_req_out), MW'(1));
        reset = 1'b0;
        #2;
        check("r_req_out", MW'(bus.resp_req_out), MW'(0));
        check("r_busy", MW'(bus.busy), MW'(0));
        check("r_msg_out", bus.auth_msg_resp_out, MW'(0));
        @(negedge clk);
        reset = 1'b1;
        bus.req_valid = 4'b1111;
        tick;
        check("r_grant_from0", MW'(bus.req_grant), MW'(4'b0001));
        bus.req_valid = '0;
        tick;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
